// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: CPU stores feed a TX FIFO, a serializer drains it as
// 8N1 frames (LSB first) on txd; STATUS reads report {overflow, full, empty, busy}.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between data and stop (8E1).
module uart_tx_periph #(
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic        wr,
    input  logic        rd,
    input  logic        addr,
    input  logic [7:0]  wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        txd
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W        = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t              state, state_nxt;
    logic [BAUD_W-1:0]   baud_cnt, baud_cnt_nxt;
    logic [2:0]          bit_cnt, bit_cnt_nxt;
    logic [7:0]          shift, shift_nxt;
    logic                txd_nxt;
    logic                pop;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr, rptr;
    logic [CNT_W-1:0]    count, count_nxt;
    logic                overflow, overflow_nxt;
    logic [31:0]         rdata_nxt;
    logic                busy_nxt;
    logic [7:0]          front;
    logic                empty, full, bit_end;
    logic                push_req, push, drop, rd_status, rd_data;
`ifdef UART_TX_PARITY_EN
    logic                par, par_nxt;
`endif

    assign front     = mem[rptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign bit_end   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign push_req  = sel & wr & ~addr;
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign rd_status = sel & rd & addr;
    assign rd_data   = sel & rd & ~addr;

    // Serializer next-state, bit timing and FIFO pop decision
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = bit_end ? '0 : baud_cnt + BAUD_W'(1);
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        txd_nxt      = txd;
        pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt      = par;
`endif
        case (state)
            S_IDLE: begin
                baud_cnt_nxt = '0;
                txd_nxt      = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = front;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = ^front;
`endif
                    txd_nxt   = 1'b0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    txd_nxt     = shift[0];
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = '0;
                    state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_nxt   = par;
                        state_nxt = S_PARITY;
`else
                        txd_nxt   = 1'b1;
                        state_nxt = S_STOP;
`endif
                    end else begin
                        txd_nxt     = shift[0];
                        shift_nxt   = shift >> 1;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    txd_nxt   = 1'b1;
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        // back-to-back frame: straight into the next start bit
                        pop       = 1'b1;
                        shift_nxt = front;
`ifdef UART_TX_PARITY_EN
                        par_nxt   = ^front;
`endif
                        txd_nxt   = 1'b0;
                        state_nxt = S_START;
                    end else begin
                        txd_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                txd_nxt      = 1'b1;
                baud_cnt_nxt = '0;
                state_nxt    = S_IDLE;
            end
        endcase
    end

    // FIFO occupancy, sticky overflow, register read data and busy look-ahead
    always_comb begin
        count_nxt    = count;
        overflow_nxt = overflow;
        rdata_nxt    = rdata;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
        if (rd_status) begin
            rdata_nxt    = {28'b0, overflow, full, empty, busy};
            overflow_nxt = 1'b0;
        end else if (rd_data) begin
            rdata_nxt = '0;
        end
        if (drop) begin
            overflow_nxt = 1'b1;
        end
        busy_nxt = (state_nxt != S_IDLE) | (count_nxt != '0);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            txd      <= txd_nxt;
            count    <= count_nxt;
            overflow <= overflow_nxt;
            rdata    <= rdata_nxt;
            busy     <= busy_nxt;
`ifdef UART_TX_PARITY_EN
            par      <= par_nxt;
`endif
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule
